// File: rtl/store_buffer_pkg.sv
// Shared definitions for the M-stage posted-write store buffer.
// The byte-enable constants are shared with the memory and the load-extend stage.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned WADDR_W  = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W_W   = 4;

    localparam logic [BE_W_W-1:0] BE_B0 = 4'b0001;
    localparam logic [BE_W_W-1:0] BE_B1 = 4'b0010;
    localparam logic [BE_W_W-1:0] BE_B2 = 4'b0100;
    localparam logic [BE_W_W-1:0] BE_B3 = 4'b1000;
    localparam logic [BE_W_W-1:0] BE_H0 = 4'b0011;
    localparam logic [BE_W_W-1:0] BE_H1 = 4'b1100;
    localparam logic [BE_W_W-1:0] BE_W  = 4'b1111;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [BE_W_W-1:0]  be;
        logic [DATA_W-1:0]  data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load/store overlap detector: flags a load touching any byte of a pending store
// in the same word.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
)
(
    input  logic [DEPTH-1:0]   i_valid,
    input  logic [WADDR_W-1:0] i_waddr [DEPTH],
    input  logic [BE_W_W-1:0]  i_be    [DEPTH],
    input  logic               i_ld_valid,
    input  logic [WADDR_W-1:0] i_ld_waddr,
    input  logic [BE_W_W-1:0]  i_ld_be,
    output logic               o_stall_c
);

    logic [DEPTH-1:0] w_hit;

    // One comparator per entry; the head still counts while it is being drained.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_hit[i] = i_valid[i] & (i_waddr[i] == i_ld_waddr) & (|(i_be[i] & i_ld_be));
        end
    end

    assign o_stall_c = i_ld_valid & (|w_hit);

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the M-stage store path and the data memory write port.
// Stores drain in program order, one per granted cycle; overlapping loads stall.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [3:0]                 st_be,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    input  logic [3:0]                 ld_be,
    output logic                       ld_stall,
    output logic                       dm_wr,
    input  logic                       dm_gnt,
    output logic [31:0]                dm_addr,
    output logic [3:0]                 dm_be,
    output logic [31:0]                dm_wd,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH+1)-1:0] sb_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    sb_entry_t          r_entry [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_enq;
    logic               w_deq;
    logic               w_match_stall;
    sb_entry_t          w_head;
    logic [WADDR_W-1:0] w_waddr [DEPTH];
    logic [BE_W_W-1:0]  w_be    [DEPTH];
    logic               w_unused;

    // Byte offsets are implied by the lane enables.
    assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

    // No bypass when full: a same-cycle drain does not free a slot until the next cycle.
    assign st_ready = (r_count < CNT_W'(DEPTH));
    assign sb_empty = (r_count == '0);
    assign sb_count = r_count;
    assign dm_wr    = !sb_empty;

    assign w_enq = st_valid & st_ready & (st_be != 4'b0000);
    assign w_deq = dm_wr & dm_gnt;

    assign w_head  = r_entry[r_rd_ptr];
    assign dm_addr = dm_wr ? {w_head.waddr, 2'b00} : 32'h0;
    assign dm_be   = dm_wr ? w_head.be : 4'b0000;
    assign dm_wd   = dm_wr ? w_head.data : 32'h0;

    // Pointers, occupancy and valid bits; pending stores are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_enq) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; it is qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entry[r_wr_ptr] <= '{waddr: st_addr[31:2], be: st_be, data: st_data};
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_waddr[i] = r_entry[i].waddr;
            w_be[i]    = r_entry[i].be;
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .i_valid    (r_valid),
        .i_waddr    (w_waddr),
        .i_be       (w_be),
        .i_ld_valid (ld_valid),
        .i_ld_waddr (ld_addr[31:2]),
        .i_ld_be    (ld_be),
        .o_stall_c  (w_match_stall)
    );

    // A store and a load together cannot come from one M-stage instruction; hold the load.
    assign ld_stall = w_match_stall | (ld_valid & st_valid);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table of per-cycle inputs and expected
// outputs, plus hand sequences for pointer wrap and asynchronous reset.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_stall;
    logic        dm_wr;
    logic        dm_gnt;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wd;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int n_chk = 0;
    int n_bad = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_be    (st_be),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_stall (ld_stall),
        .dm_wr    (dm_wr),
        .dm_gnt   (dm_gnt),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wd    (dm_wd),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sv;
        logic [31:0] sa;
        logic [3:0]  sbe;
        logic [31:0] sd;
        bit          lv;
        logic [31:0] la;
        logic [3:0]  lbe;
        bit          gnt;
        bit          e_rdy;
        bit          e_stl;
        bit          e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        bit          e_emp;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] Z32 = 32'h0;
    localparam logic [3:0]  Z4  = 4'h0;

    function automatic vec_t mk(
        input bit sv, input logic [31:0] sa, input logic [3:0] sbe, input logic [31:0] sd,
        input bit lv, input logic [31:0] la, input logic [3:0] lbe, input bit gnt,
        input bit rdy, input bit stl, input bit wr, input logic [31:0] ea,
        input logic [3:0] ebe, input logic [31:0] ewd, input bit emp, input logic [2:0] cnt);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sbe = sbe; v.sd = sd;
        v.lv = lv; v.la = la; v.lbe = lbe; v.gnt = gnt;
        v.e_rdy = rdy; v.e_stl = stl; v.e_wr = wr; v.e_addr = ea;
        v.e_be = ebe; v.e_wd = ewd; v.e_emp = emp; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = Z32; st_be = Z4; st_data = Z32;
        ld_valid = 1'b0; ld_addr = Z32; ld_be = Z4; dm_gnt = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        st_valid = v.sv; st_addr = v.sa; st_be = v.sbe; st_data = v.sd;
        ld_valid = v.lv; ld_addr = v.la; ld_be = v.lbe; dm_gnt = v.gnt;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".st_ready"}, 32'(st_ready), 32'(v.e_rdy));
        chk({tag, ".ld_stall"}, 32'(ld_stall), 32'(v.e_stl));
        chk({tag, ".dm_wr"},    32'(dm_wr),    32'(v.e_wr));
        chk({tag, ".dm_addr"},  dm_addr,       v.e_addr);
        chk({tag, ".dm_be"},    32'(dm_be),    32'(v.e_be));
        chk({tag, ".dm_wd"},    dm_wd,         v.e_wd);
        chk({tag, ".sb_empty"}, 32'(sb_empty), 32'(v.e_emp));
        chk({tag, ".sb_count"}, 32'(sb_count), 32'(v.e_cnt));
    endtask

    initial begin
        // Reset state, then single sw drained under grant.
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b1, 32'h10, BE_W, 32'hDEADBEEF, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h10, BE_W, 32'hDEADBEEF, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        // Fill to four without grant, fifth rejected, then in-order drain.
        vecs.push_back(mk(1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b1, 32'h4, BE_W, 32'h22222222, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, 3'd1));
        vecs.push_back(mk(1'b1, 32'h8, BE_W, 32'h33333333, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, 32'hC, BE_W, 32'h44444444, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, 3'd3));
        vecs.push_back(mk(1'b1, 32'h10, BE_W, 32'h55555555, 1'b0, Z32, Z4, 1'b0,  1'b0, 1'b0, 1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, 3'd4));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b0, 1'b0, 1'b1, 32'h0, BE_W, 32'h11111111, 1'b0, 3'd4));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h4, BE_W, 32'h22222222, 1'b0, 3'd3));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h8, BE_W, 32'h33333333, 1'b0, 3'd2));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'hC, BE_W, 32'h44444444, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        // Pending sb to 0x21 and overlapping / non-overlapping loads.
        vecs.push_back(mk(1'b1, 32'h21, BE_B1, 32'h0000AB00, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h21, BE_B1, 1'b0,  1'b1, 1'b1, 1'b1, 32'h20, BE_B1, 32'h0000AB00, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h22, BE_B2, 1'b0,  1'b1, 1'b0, 1'b1, 32'h20, BE_B1, 32'h0000AB00, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h20, BE_W, 1'b0,  1'b1, 1'b1, 1'b1, 32'h20, BE_B1, 32'h0000AB00, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h25, BE_B1, 1'b0,  1'b1, 1'b0, 1'b1, 32'h20, BE_B1, 32'h0000AB00, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h21, BE_B1, 1'b1,  1'b1, 1'b1, 1'b1, 32'h20, BE_B1, 32'h0000AB00, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b1, 32'h21, BE_B1, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        // Illegal store+load: store queued, load held.
        vecs.push_back(mk(1'b1, 32'h30, BE_W, 32'hCAFEF00D, 1'b1, 32'h40, BE_W, 1'b0,  1'b1, 1'b1, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h30, BE_W, 32'hCAFEF00D, 1'b0, 3'd1));
        // Zero byte-enable store accepted but not queued.
        vecs.push_back(mk(1'b1, 32'h50, Z4, 32'h12345678, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h30, BE_W, 32'hCAFEF00D, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h30, BE_W, 32'hCAFEF00D, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        // Full with grant: store refused that cycle, accepted the next.
        vecs.push_back(mk(1'b1, 32'h100, BE_W, 32'hA0000000, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));
        vecs.push_back(mk(1'b1, 32'h104, BE_W, 32'hA0000001, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h100, BE_W, 32'hA0000000, 1'b0, 3'd1));
        vecs.push_back(mk(1'b1, 32'h108, BE_W, 32'hA0000002, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h100, BE_W, 32'hA0000000, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, 32'h10C, BE_W, 32'hA0000003, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h100, BE_W, 32'hA0000000, 1'b0, 3'd3));
        vecs.push_back(mk(1'b1, 32'h110, BE_W, 32'hA0000004, 1'b0, Z32, Z4, 1'b1,  1'b0, 1'b0, 1'b1, 32'h100, BE_W, 32'hA0000000, 1'b0, 3'd4));
        vecs.push_back(mk(1'b1, 32'h110, BE_W, 32'hA0000004, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b1, 32'h104, BE_W, 32'hA0000001, 1'b0, 3'd3));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b0, 1'b0, 1'b1, 32'h104, BE_W, 32'hA0000001, 1'b0, 3'd4));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h108, BE_W, 32'hA0000002, 1'b0, 3'd3));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h10C, BE_W, 32'hA0000003, 1'b0, 3'd2));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b1,  1'b1, 1'b0, 1'b1, 32'h110, BE_W, 32'hA0000004, 1'b0, 3'd1));
        vecs.push_back(mk(1'b0, Z32, Z4, Z32, 1'b0, Z32, Z4, 1'b0,  1'b1, 1'b0, 1'b0, Z32, Z4, Z32, 1'b1, 3'd0));

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Inputs change on the falling edge; outputs sampled 1 time unit later.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Pointer wrap: ten back-to-back stores under continuous grant.
        for (int k = 0; k <= 10; k++) begin
            idle_inputs();
            st_valid = (k < 10);
            st_addr  = 32'h200 + 32'(4 * k);
            st_be    = BE_W;
            st_data  = 32'hB0000000 + 32'(k);
            dm_gnt   = 1'b1;
            #1;
            chk($sformatf("wrap%0d.sb_count", k), 32'(sb_count), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) begin
                chk($sformatf("wrap%0d.dm_addr", k), dm_addr, 32'h200 + 32'(4 * (k - 1)));
                chk($sformatf("wrap%0d.dm_wd", k), dm_wd, 32'hB0000000 + 32'(k - 1));
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("wrap_end.sb_empty", 32'(sb_empty), 32'd1);
        @(negedge clk);

        // Asynchronous reset with three pending entries.
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            st_valid = 1'b1;
            st_addr  = 32'h300 + 32'(4 * k);
            st_be    = BE_W;
            st_data  = 32'hC0000000 + 32'(k);
            @(negedge clk);
        end
        idle_inputs();
        ld_valid = 1'b1;
        ld_addr  = 32'h304;
        ld_be    = BE_W;
        #1;
        chk("prerst.ld_stall", 32'(ld_stall), 32'd1);
        chk("prerst.sb_count", 32'(sb_count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.dm_wr",    32'(dm_wr),    32'd0);
        chk("rst.sb_count", 32'(sb_count), 32'd0);
        chk("rst.ld_stall", 32'(ld_stall), 32'd0);
        chk("rst.sb_empty", 32'(sb_empty), 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        ld_valid = 1'b0;
        dm_gnt   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("postrst%0d.dm_wr", k), 32'(dm_wr), 32'd0);
            chk($sformatf("postrst%0d.sb_count", k), 32'(sb_count), 32'd0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
